// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard/stall/flush control for the 5-stage RV32I core, with LSU wait-state FSM.
// Optional performance counters are built when PIPE_CTRL_PERF_EN is defined.
module pipe_hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        reset_ni,
    input  logic [4:0]  id_rs1_addr_i,
    input  logic [4:0]  id_rs2_addr_i,
    input  logic        id_rs1_use_i,
    input  logic        id_rs2_use_i,
    input  logic [4:0]  ex_rd_addr_i,
    input  logic        ex_rd_wren_i,
    input  logic        ex_is_load_i,
    input  logic        ex_redirect_i,
    input  logic        mem_access_i,
    input  logic        mem_ack_i,
    output logic        pc_en_o,
    output logic        if_id_en_o,
    output logic        id_ex_en_o,
    output logic        ex_mem_en_o,
    output logic        mem_wb_en_o,
    output logic        if_id_flush_o,
    output logic        id_ex_flush_o,
    output logic        mem_wb_flush_o,
    output logic        mem_wait_o,
    output logic        err_o,
    output logic [31:0] stall_cnt_o,
    output logic [31:0] flush_cnt_o
);

    localparam int unsigned CW = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic          r_err;

    logic w_load_use;
    logic w_timeout;
    logic w_mem_stall;

    assign w_load_use = ex_is_load_i && ex_rd_wren_i && (ex_rd_addr_i != 5'd0) &&
                        ((id_rs1_use_i && (id_rs1_addr_i == ex_rd_addr_i)) ||
                         (id_rs2_use_i && (id_rs2_addr_i == ex_rd_addr_i)));

    assign w_timeout = (r_state == MEM_WAIT) && (r_cnt == CW'(MEM_TIMEOUT - 1));

    assign w_mem_stall = ((r_state == RUN) && mem_access_i && !mem_ack_i) ||
                         ((r_state == MEM_WAIT) && !mem_ack_i && !w_timeout);

    always_comb begin
        w_state_nxt    = r_state;
        pc_en_o        = 1'b1;
        if_id_en_o     = 1'b1;
        id_ex_en_o     = 1'b1;
        ex_mem_en_o    = 1'b1;
        mem_wb_en_o    = 1'b1;
        if_id_flush_o  = 1'b0;
        id_ex_flush_o  = 1'b0;
        mem_wb_flush_o = 1'b0;

        case (r_state)
            RUN:      if (mem_access_i && !mem_ack_i) w_state_nxt = MEM_WAIT;
            MEM_WAIT: if (mem_ack_i || w_timeout)     w_state_nxt = RUN;
            default:  w_state_nxt = RUN;
        endcase

        if (!reset_ni) begin
            pc_en_o     = 1'b0;
            if_id_en_o  = 1'b0;
            id_ex_en_o  = 1'b0;
            ex_mem_en_o = 1'b0;
            mem_wb_en_o = 1'b0;
        end else if (w_mem_stall) begin
            // Freeze the front; WB still advances but receives a bubble.
            pc_en_o        = 1'b0;
            if_id_en_o     = 1'b0;
            id_ex_en_o     = 1'b0;
            ex_mem_en_o    = 1'b0;
            mem_wb_flush_o = 1'b1;
        end else if (ex_redirect_i) begin
            if_id_flush_o = 1'b1;
            id_ex_flush_o = 1'b1;
        end else if (w_load_use) begin
            pc_en_o       = 1'b0;
            if_id_en_o    = 1'b0;
            id_ex_flush_o = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            r_state <= RUN;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= (r_state == MEM_WAIT) ? r_cnt + 1'b1 : '0;
            if (w_timeout) r_err <= 1'b1;
        end
    end

    assign mem_wait_o = reset_ni && (r_state == MEM_WAIT);
    assign err_o      = r_err;

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (!pc_en_o) r_stall_cnt <= r_stall_cnt + 32'd1;
            if (!w_mem_stall && ex_redirect_i) r_flush_cnt <= r_flush_cnt + 32'd1;
        end
    end

    assign stall_cnt_o = r_stall_cnt;
    assign flush_cnt_o = r_flush_cnt;
`else
    assign stall_cnt_o = '0;
    assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed hazard scenarios followed by random traffic.
module tb_pipe_hazard_ctrl;

    localparam int unsigned TMO = 4;

    logic        clk = 1'b0;
    logic        reset_ni;
    logic [4:0]  id_rs1_addr, id_rs2_addr, ex_rd_addr;
    logic        id_rs1_use, id_rs2_use, ex_rd_wren, ex_is_load, ex_redirect;
    logic        mem_access, mem_ack;
    logic        pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic        if_id_flush, id_ex_flush, mem_wb_flush, mem_wait, err;
    logic [31:0] stall_cnt, flush_cnt;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(TMO)) dut (
        .clk_i(clk), .reset_ni(reset_ni),
        .id_rs1_addr_i(id_rs1_addr), .id_rs2_addr_i(id_rs2_addr),
        .id_rs1_use_i(id_rs1_use), .id_rs2_use_i(id_rs2_use),
        .ex_rd_addr_i(ex_rd_addr), .ex_rd_wren_i(ex_rd_wren), .ex_is_load_i(ex_is_load),
        .ex_redirect_i(ex_redirect), .mem_access_i(mem_access), .mem_ack_i(mem_ack),
        .pc_en_o(pc_en), .if_id_en_o(if_id_en), .id_ex_en_o(id_ex_en),
        .ex_mem_en_o(ex_mem_en), .mem_wb_en_o(mem_wb_en),
        .if_id_flush_o(if_id_flush), .id_ex_flush_o(id_ex_flush), .mem_wb_flush_o(mem_wb_flush),
        .mem_wait_o(mem_wait), .err_o(err),
        .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
    );

    typedef struct {
        bit        rst_n;
        bit [4:0]  en;   // {pc, if_id, id_ex, ex_mem, mem_wb}
        bit [2:0]  fl;   // {if_id, id_ex, mem_wb}
        bit        mw;
        bit        err;
        bit [31:0] sc;
        bit [31:0] fc;
    } exp_t;

    exp_t q[$];
    int   n_total = 0;
    int   n_pass  = 0;

    // Reference model state: abstract "waiting" flag and number of wait cycles elapsed.
    bit          m_wait = 0;
    int unsigned m_wc   = 0;
    bit          m_err  = 0;
    bit [31:0]   m_sc   = 0;
    bit [31:0]   m_fc   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    endtask

    task automatic step(input bit rst_n, input bit [4:0] rs1, input bit [4:0] rs2,
                        input bit u1, input bit u2, input bit [4:0] rd, input bit wren,
                        input bit ld, input bit redir, input bit acc, input bit ack);
        exp_t e;
        bit   lu, to, stall;
        @(posedge clk);
        #1;
        reset_ni = rst_n; id_rs1_addr = rs1; id_rs2_addr = rs2; id_rs1_use = u1;
        id_rs2_use = u2; ex_rd_addr = rd; ex_rd_wren = wren; ex_is_load = ld;
        ex_redirect = redir; mem_access = acc; mem_ack = ack;

        e.rst_n = rst_n;
        e.mw    = rst_n && m_wait;
        e.err   = m_err;
`ifdef PIPE_CTRL_PERF_EN
        e.sc = m_sc;
        e.fc = m_fc;
`else
        e.sc = 0;
        e.fc = 0;
`endif
        if (!rst_n) begin
            e.en = 5'b00000; e.fl = 3'b000;
            m_wait = 0; m_wc = 0; m_err = 0; m_sc = 0; m_fc = 0;
        end else begin
            lu = ld && wren && rd != 0 && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
            to = m_wait && (m_wc == TMO - 1);
            stall = m_wait ? (!ack && !to) : (acc && !ack);
            if (stall)      begin e.en = 5'b00001; e.fl = 3'b001; end
            else if (redir) begin e.en = 5'b11111; e.fl = 3'b110; m_fc++; end
            else if (lu)    begin e.en = 5'b00111; e.fl = 3'b010; end
            else            begin e.en = 5'b11111; e.fl = 3'b000; end
            if (!e.en[4]) m_sc++;
            if (m_wait) begin
                if (to) m_err = 1;
                if (ack || to) begin m_wait = 0; m_wc = 0; end
                else m_wc++;
            end else if (acc && !ack) begin
                m_wait = 1; m_wc = 0;
            end
        end
        q.push_back(e);
    endtask

    task automatic idle(input bit rst_n);
        step(rst_n, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: outputs are valid every cycle; compare against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("enables", {27'd0, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en}, {27'd0, e.en});
                if (e.en[3] || !e.rst_n) chk("if_id_flush", {31'd0, if_id_flush}, {31'd0, e.fl[2]});
                if (e.en[2] || !e.rst_n) chk("id_ex_flush", {31'd0, id_ex_flush}, {31'd0, e.fl[1]});
                if (e.en[0] || !e.rst_n) chk("mem_wb_flush", {31'd0, mem_wb_flush}, {31'd0, e.fl[0]});
                chk("mem_wait", {31'd0, mem_wait}, {31'd0, e.mw});
                chk("err", {31'd0, err}, {31'd0, e.err});
                chk("stall_cnt", stall_cnt, e.sc);
                chk("flush_cnt", flush_cnt, e.fc);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_ni = 0; id_rs1_addr = 0; id_rs2_addr = 0; id_rs1_use = 0; id_rs2_use = 0;
        ex_rd_addr = 0; ex_rd_wren = 0; ex_is_load = 0; ex_redirect = 0;
        mem_access = 0; mem_ack = 0;
        @(posedge clk);
        idle(0); idle(0); idle(1);

        // load-use on rs1 then clean advance
        step(1, 5, 7, 1, 1, 5, 1, 1, 0, 0, 0);
        idle(1);
        // load-use on rs2
        step(1, 1, 9, 1, 1, 9, 1, 1, 0, 0, 0);
        // load to x0 with ID reading x0
        step(1, 0, 0, 1, 1, 0, 1, 1, 0, 0, 0);
        // matching rd but not a load / not writing
        step(1, 5, 0, 1, 0, 5, 1, 0, 0, 0, 0);
        step(1, 5, 0, 1, 0, 5, 0, 1, 0, 0, 0);
        // redirect together with load-use
        step(1, 5, 0, 1, 0, 5, 1, 1, 1, 0, 0);
        idle(1);
        // store acked 3 cycles after MEM entry
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        idle(1);
        // stray ack with no access
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        // access with no ack: timeout, then the same access stalls again, then ack
        for (int i = 0; i < 8; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        idle(1); idle(1);
        // reset pulse in the middle of a wait
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        step(0, 3, 3, 1, 1, 3, 1, 1, 1, 1, 0);
        step(0, 3, 3, 1, 1, 3, 1, 1, 1, 1, 0);
        idle(1); idle(1);

        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 199) != 0,
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 1'($urandom), 1'($urandom),
                 5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
                 $urandom_range(0, 4) == 0,
                 $urandom_range(0, 2) == 0,
                 $urandom_range(0, 5) == 0);
        end

        idle(1);
        @(negedge clk);
        @(negedge clk);
        chk("queue_drained", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline control unit for the 5-stage RV32I core. It drives the enable and flush inputs of the PC register and of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves three conditions: load-use hazards, taken-branch/jump redirects, and multi-cycle LSU accesses that are waiting in the MEM stage. A wait-state FSM with a timeout counter handles the LSU case.

## Interface
Parameters:
- MEM_TIMEOUT, default 255: maximum number of MEM_WAIT cycles before a forced release; legal range 1..65535.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge
- reset_ni  in  1  synchronous, active-low reset
- id_rs1_addr_i  in  5  rs1 index of the instruction in ID
- id_rs2_addr_i  in  5  rs2 index of the instruction in ID
- id_rs1_use_i  in  1  the ID instruction reads rs1
- id_rs2_use_i  in  1  the ID instruction reads rs2
- ex_rd_addr_i  in  5  rd index of the instruction in EX
- ex_rd_wren_i  in  1  the EX instruction writes rd
- ex_is_load_i  in  1  the EX instruction is a load
- ex_redirect_i  in  1  branch taken or jump resolved in EX
- mem_access_i  in  1  the MEM stage holds a load or store (is_load | mem_wren)
- mem_ack_i  in  1  LSU access complete, one-cycle pulse
- pc_en_o, if_id_en_o, id_ex_en_o, ex_mem_en_o, mem_wb_en_o  out  1 each  register enables
- if_id_flush_o, id_ex_flush_o, mem_wb_flush_o  out  1 each  load a NOP/bubble on the next edge
- mem_wait_o  out  1  the FSM is in MEM_WAIT
- err_o  out  1  sticky LSU timeout flag
- stall_cnt_o, flush_cnt_o  out  32 each  performance counters (see Configuration)

## Operation
- FSM states: RUN and MEM_WAIT.
- Definitions:
  - load_use = ex_is_load_i & ex_rd_wren_i & ex_rd_addr_i≠0 & ((id_rs1_use_i & rs1==rd) | (id_rs2_use_i & rs2==rd)).
  - mem_stall = (state==RUN & mem_access_i & !mem_ack_i) | (state==MEM_WAIT & !mem_ack_i & !timeout).
- Priority 1, mem_stall:
  - pc/if_id/id_ex/ex_mem enables = 0.
  - mem_wb_en_o = 1 and mem_wb_flush_o = 1, so a bubble enters WB.
  - Redirect and load-use are ignored in that cycle; they re-evaluate after release because EX is frozen.
- Priority 2, ex_redirect_i:
  - All enables = 1; if_id_flush_o = 1 and id_ex_flush_o = 1.
  - A load_use in the same cycle is discarded, because ID is wrong-path.
- Priority 3, load_use:
  - pc_en_o = 0 and if_id_en_o = 0.
  - id_ex_en_o = 1 with id_ex_flush_o = 1; ex_mem and mem_wb enables = 1.
- Otherwise: all enables = 1, all flushes = 0.
- Transitions:
  - RUN→MEM_WAIT when mem_access_i & !mem_ack_i.
  - MEM_WAIT→RUN on mem_ack_i or on timeout.
  - A mem_ack_i received while in RUN with mem_access_i=0 is ignored.
- Timeout counter, width clog2(MEM_TIMEOUT+1):
  - Cleared in RUN; increments each MEM_WAIT cycle.
  - timeout = (cnt == MEM_TIMEOUT-1) while in MEM_WAIT.
  - On timeout the FSM releases exactly as on an ack and sets err_o.
- err_o clears only on reset.
- Flush outputs are meaningful only when the matching enable is 1.

## Timing
- All enable/flush outputs are combinational from the inputs and the registered state; there is no added latency.
- The FSM and counter update on the rising edge.
- Load-use costs exactly 1 bubble; redirect costs 2 flushed slots.
- An access with N wait cycles (ack N cycles after MEM entry) freezes the front pipeline for N cycles. The cycle in which mem_ack_i is high is a normal advance cycle.
- Reset (reset_ni=0 at an edge): state=RUN, counter=0, err_o=0, counters=0.
- While reset_ni=0: all enables and flushes = 0, mem_wait_o=0.
- Reset asserted in MEM_WAIT aborts the wait; the next cycle is RUN.

## Configuration
- PIPE_CTRL_PERF_EN defined:
  - stall_cnt_o increments on every cycle with pc_en_o=0 (mem_stall or load_use).
  - flush_cnt_o increments on every cycle with ex_redirect_i honoured.
  - Both wrap at 2^32 and clear on reset.
- Not defined: both outputs are constant 0 and no counter flops are built.

## Test plan
- Load-use: EX is lw x5 (rd_wren=1); ID reads rs1=x5 → exactly one cycle with pc_en=0, if_id_en=0, id_ex_flush=1; the next cycle has all enables = 1.
- Load to x0 with ID reading x0 → no stall.
- Redirect and load_use in the same cycle → if_id_flush=1, id_ex_flush=1, pc_en=1; flush_cnt_o +1 when PERF enabled.
- Store with ack 3 cycles after MEM entry → mem_wait_o high 3 cycles, front enables 0, mem_wb_flush=1 each of those cycles; RUN in the ack cycle.
- MEM_TIMEOUT=4, no ack → release after 4 MEM_WAIT cycles, err_o=1 and held; the next access still stalls normally.
- Reset pulse during MEM_WAIT → all outputs 0 during reset; RUN, err_o=0 and counters 0 after.
